// File: rtl/popcount_accum_seq.sv
// Pipelined popcount accumulator: counts set bits per handshaked beat, sums them
// over a frame and returns sum, threshold-fire and overflow on a valid/ready output.
module popcount_accum_seq #(
  parameter int N         = 21,
  parameter int MAX_BEATS = 8,
  parameter int APX_W     = 2,
  localparam int OUT_W    = $clog2(N * MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  input  logic             cfg_mode,
  input  logic [OUT_W-1:0] cfg_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic             out_fire,
  output logic             out_ovf
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // A producer holds valid and its payload until that edge; ready never depends on
  // valid combinationally.

  localparam int PC_W  = $clog2(N + 1);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);
  localparam logic [OUT_W:0]   SAT_MAX  = (OUT_W + 1)'(N * MAX_BEATS);
  localparam logic [PC_W-1:0]  APX_MASK = {PC_W{1'b1}} << APX_W;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             in_fire, out_fire_hs, first_beat, eff_mode;
  logic [PC_W-1:0]  pc_raw, pc;
  logic             s1_valid, s1_last;
  logic [PC_W-1:0]  s1_pc;
  logic [OUT_W-1:0] acc_q, acc_next;
  logic [OUT_W:0]   acc_add;
  logic             acc_over;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             ovf_q, fin_q, mode_q;
  logic [OUT_W-1:0] thresh_q;

  assign in_fire     = in_valid & in_ready;
  assign out_fire_hs = out_valid & out_ready;
  assign first_beat  = (beat_cnt_q == '0);
  // The first beat uses the live mode; later beats use the mode held for the frame.
  assign eff_mode    = first_beat ? cfg_mode : mode_q;

  always_comb begin
    pc_raw = '0;
    for (int i = 0; i < N; i++) begin
      pc_raw = pc_raw + PC_W'(in_data[i]);
    end
    pc = eff_mode ? (pc_raw & APX_MASK) : pc_raw;
  end

  always_comb begin
    acc_add  = {1'b0, acc_q} + (OUT_W + 1)'(s1_pc);
    acc_over = (acc_add > SAT_MAX);
    acc_next = acc_over ? SAT_MAX[OUT_W-1:0] : acc_add[OUT_W-1:0];
  end

  // Stage 1: registered per-beat count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_pc    <= '0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_pc   <= pc;
        s1_last <= in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 1'b0;
      thresh_q <= '0;
    end else if (in_fire && first_beat) begin
      mode_q   <= cfg_mode;
      thresh_q <= cfg_thresh;
    end
  end

  // Stage 2: accumulator, beat counter and sticky overflow, cleared when a result loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      fin_q <= s1_valid & s1_last;
      if (fin_q) begin
        acc_q      <= '0;
        beat_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (s1_valid) begin
          acc_q <= acc_next;
          if (acc_over) ovf_q <= 1'b1;
        end
        if (in_fire) begin
          if (beat_cnt_q == CNT_MAX) ovf_q <= 1'b1;
          else                       beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_fire  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (fin_q) begin
      out_valid <= 1'b1;
      out_sum   <= acc_q;
      out_fire  <= (acc_q >= thresh_q);
      out_ovf   <= ovf_q;
    end else if (out_fire_hs) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (in_fire && in_last) state_d = HOLD;
      HOLD:    if (out_fire_hs)        state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ACC);
  end

endmodule

// File: tb/tb_popcount_accum_seq.sv
// Randomized bench for popcount_accum_seq: a frame-level reference model feeds an
// expected queue that is checked at every output handshake.
module tb_popcount_accum_seq;
  localparam int N         = 21;
  localparam int MAX_BEATS = 8;
  localparam int APX_W     = 2;
  localparam int OUT_W     = $clog2(N * MAX_BEATS + 1);
  localparam int SAT       = N * MAX_BEATS;
  localparam int RW        = OUT_W + 2;

  logic             clk, rst;
  logic             in_valid, in_ready, in_last, cfg_mode;
  logic [N-1:0]     in_data;
  logic [OUT_W-1:0] cfg_thresh, out_sum;
  logic             out_valid, out_ready, out_fire, out_ovf;

  popcount_accum_seq #(.N(N), .MAX_BEATS(MAX_BEATS), .APX_W(APX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_fire(out_fire), .out_ovf(out_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int acc_edge = 0;
  logic busy = 1'b0;
  logic rdy_force = 1'b1;
  logic rdy_val = 1'b1;
  logic [RW-1:0] exp_q[$];
  logic [N-1:0] frame_data[16];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) ncyc++;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_force ? rdy_val : ($urandom_range(0, 1) == 1);
    end
  end

  // driver tasks
  task automatic drive_idle();
    in_valid   = 1'b0;
    in_data    = N'($urandom);
    in_last    = 1'($urandom);
    cfg_mode   = 1'($urandom);
    cfg_thresh = OUT_W'($urandom);
  endtask

  task automatic drive_beat(input logic [N-1:0] d, input logic last, input logic mode,
                            input logic [OUT_W-1:0] th);
    int w;
    in_valid = 1'b1; in_data = d; in_last = last; cfg_mode = mode; cfg_thresh = th;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("beat_accept_timeout", w, 0);
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  // Reference model: frame-level arithmetic on the beats of frame_data.
  task automatic send_frame(input int n, input logic mode, input logic [OUT_W-1:0] th,
                            input logic toggle, input logic gaps);
    int total, c, sum;
    logic ovf, fire, m;
    total = 0;
    for (int i = 0; i < n; i++) begin
      c = $countones(frame_data[i]);
      if (mode) c = c - (c % (1 << APX_W));
      total += c;
    end
    sum  = (total > SAT) ? SAT : total;
    ovf  = (n > MAX_BEATS) || (total > SAT);
    fire = (sum >= int'(th));
    exp_q.push_back({ovf, fire, OUT_W'(sum)});
    for (int i = 0; i < n; i++) begin
      m = (i == 0) ? mode : (toggle ? ~mode : 1'($urandom));
      drive_beat(frame_data[i], (i == n - 1), m, (i == 0) ? th : OUT_W'($urandom));
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string tag);
    int w;
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check(tag, (w < 100), 1);
  endtask

  // scoreboard / protocol monitor
  logic             prev_valid = 1'b0, prev_ready = 1'b0, prev_fire = 1'b0, prev_ovf = 1'b0;
  logic [OUT_W-1:0] prev_sum = '0;
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        busy = 1'b0;
      end else begin
        check("in_ready", in_ready, !busy);
        if (out_valid && !prev_valid) begin
          check("latency", ncyc - acc_edge, 2);
          check("unexpected_out", (exp_q.size() > 0), 1);
        end
        if (out_valid && prev_valid && !prev_ready) begin
          check("hold_sum", out_sum, prev_sum);
          check("hold_fire", out_fire, prev_fire);
          check("hold_ovf", out_ovf, prev_ovf);
        end
        if (in_valid && in_ready && in_last) begin
          busy = 1'b1;
          acc_edge = ncyc + 1;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_sum", out_sum, e[OUT_W-1:0]);
            check("out_fire", out_fire, e[OUT_W]);
            check("out_ovf", out_ovf, e[OUT_W+1]);
          end
          busy = 1'b0;
        end
        prev_valid = out_valid; prev_ready = out_ready;
        prev_sum = out_sum; prev_fire = out_fire; prev_ovf = out_ovf;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sum"}, out_sum, 0);
    check({tag, "_out_fire"}, out_fire, 0);
    check({tag, "_out_ovf"}, out_ovf, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic async_reset_pulse();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // exact single beat
    frame_data[0] = 21'h1FFFFF;
    send_frame(1, 1'b0, OUT_W'(21), 1'b0, 1'b0);
    wait_drain();

    // exact and approximate 3-beat frames (approx with mode toggled on later beats)
    frame_data[0] = 21'h1FFFFF; frame_data[1] = 21'h000001; frame_data[2] = 21'h0000FF;
    send_frame(3, 1'b0, OUT_W'(31), 1'b0, 1'b0);
    wait_drain();
    send_frame(3, 1'b1, OUT_W'(28), 1'b1, 1'b0);
    wait_drain();

    // backpressure with a queued next frame
    rdy_val = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) frame_data[i] = N'($urandom);
        send_frame(3, 1'b0, OUT_W'($urandom_range(0, SAT)), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) frame_data[i] = N'($urandom);
        send_frame(2, 1'b1, OUT_W'($urandom_range(0, SAT)), 1'b0, 1'b0);
      end
      begin
        wait_out_valid("bp_out_valid");
        repeat (5) @(posedge clk);
        #1;
        rdy_val = 1'b1;
      end
    join
    wait_drain();

    // exactly MAX_BEATS full beats, then overflow by beat count, then a clean frame
    for (int i = 0; i < 16; i++) frame_data[i] = 21'h1FFFFF;
    send_frame(MAX_BEATS, 1'b0, OUT_W'(SAT), 1'b0, 1'b0);
    send_frame(10, 1'b0, OUT_W'(100), 1'b0, 1'b0);
    wait_drain();
    frame_data[0] = 21'h000003;
    send_frame(1, 1'b0, OUT_W'(3), 1'b0, 1'b0);
    wait_drain();

    // reset mid-frame, then a fresh frame
    drive_beat(21'h1FFFFF, 1'b0, 1'b0, OUT_W'(0));
    drive_beat(21'h1FFFFF, 1'b0, 1'b0, OUT_W'(0));
    async_reset_pulse();
    frame_data[0] = 21'h00000F;
    send_frame(1, 1'b0, OUT_W'(4), 1'b0, 1'b0);
    wait_drain();

    // reset while a result is held
    rdy_val = 1'b0;
    frame_data[0] = 21'h0F0F0F;
    send_frame(1, 1'b0, OUT_W'(1), 1'b0, 1'b0);
    wait_out_valid("hold_out_valid");
    async_reset_pulse();
    rdy_val = 1'b1;
    frame_data[0] = 21'h000007;
    send_frame(1, 1'b1, OUT_W'(2), 1'b0, 1'b0);
    wait_drain();

    // random frames with random output backpressure
    rdy_force = 1'b0;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, MAX_BEATS + 3);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       frame_data[i] = '1;
          1:       frame_data[i] = '0;
          default: frame_data[i] = N'($urandom);
        endcase
      end
      send_frame(n, 1'($urandom), OUT_W'($urandom_range(0, SAT)), 1'($urandom), 1'b1);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
